dabble_seq: RTL and testbench

Sequencer that sits directly upstream of the bit-serial double-dabble register chain. It accepts a parallel binary word on a start strobe and clears the chain. It then feeds the word into the chain MSB-first, one bit per shift cycle, and finally captures the chain's parallel BCD digits into an output register with a one-cycle done pulse. Its output feeds the display path that consumes the BCD digits.

---
 rtl/dabble_seq.sv | 165 ++++++++++++++++
 tb/tb_dabble_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dabble_seq.sv
// dabble_seq
//   Sequencer in front of a bit-serial double-dabble register chain.
//   On an accepted start it latches a binary word and clears the chain for one
//   cycle. It then streams the word into the chain MSB-first, one bit per shift
//   cycle, and latches the chain's parallel BCD digits with a one-cycle done
//   pulse.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        conversion request, only honoured in IDLE
//   bin          binary word, latched when start is accepted
//   busy         conversion in progress (low in the done cycle)
//   chain_clr    synchronous clear to the dabble chain
//   chain_shift  shift enable to the dabble chain
//   chain_din    serial bit into the chain's least-significant cell
//   chain_bcd    parallel digits from the chain, digit 0 in [3:0]
//   bcd          latched result, held until the next capture
//   done         one-cycle pulse, bcd valid from this cycle on
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; done may be high for one cycle here
// CLEAR   | chain_clr asserted, chain being zeroed
// SHIFT   | chain_shift asserted, one bin_q bit fed per edge
// CAPTURE | chain settled, digits latched into bcd on the next edge

module dabble_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  chain_clr,
   output logic                  chain_shift,
   output logic                  chain_din,
   input  logic [4*DIGITS-1:0]   chain_bcd,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done
);

   // Number of decimal digits needed to hold 2^w - 1.
   function automatic int digits_needed(input int w);
      longint unsigned v;
      int              n;
      v = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      n = 1;
      v = v / 64'd10;
      while (v != 64'd0) begin
         n++;
         v = v / 64'd10;
      end
      return n;
   endfunction

   localparam int DIG_NEED = digits_needed(WIDTH);

   generate
      if (WIDTH < 1) begin : g_bad_width
         $error("dabble_seq: WIDTH must be at least 1");
      end
      if (DIGITS < DIG_NEED) begin : g_bad_digits
         $error("dabble_seq: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
      end
   endgenerate

   localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CLEAR   = 2'd1,
      SHIFT   = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       bin_q, bin_d;
   logic [WIDTH-1:0]       bin_shl;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   busy_d, clr_d, shift_d, din_d, done_d;
   logic [4*DIGITS-1:0]    bcd_d;

   assign bin_shl = bin_q << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         cnt_q       <= '0;
         busy        <= 1'b0;
         chain_clr   <= 1'b0;
         chain_shift <= 1'b0;
         chain_din   <= 1'b0;
         bcd         <= '0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         cnt_q       <= cnt_d;
         busy        <= busy_d;
         chain_clr   <= clr_d;
         chain_shift <= shift_d;
         chain_din   <= din_d;
         bcd         <= bcd_d;
         done        <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      cnt_d   = cnt_q;
      busy_d  = busy;
      clr_d   = 1'b0;
      shift_d = chain_shift;
      din_d   = chain_din;
      bcd_d   = bcd;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               bin_d   = bin;
               busy_d  = 1'b1;
               clr_d   = 1'b1;
            end
         end
         CLEAR: begin
            state_d = SHIFT;
            cnt_d   = '0;
            shift_d = 1'b1;
            din_d   = bin_q[WIDTH-1];
         end
         SHIFT: begin
            // chain_din is registered, so it is loaded with the MSB that
            // bin_q will hold after this edge.
            bin_d = bin_shl;
            cnt_d = cnt_q + CNT_ONE;
            din_d = bin_shl[WIDTH-1];
            if (cnt_q == CNT_LAST) begin
               state_d = CAPTURE;
               cnt_d   = '0;
               shift_d = 1'b0;
               din_d   = 1'b0;
            end
         end
         CAPTURE: begin
            state_d = IDLE;
            bcd_d   = chain_bcd;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dabble_seq.sv
module tb_dabble_seq;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [WIDTH-1:0]    bin = '0;
   logic                busy, chain_clr, chain_shift, chain_din, done;
   logic [4*DIGITS-1:0] chain_bcd, bcd;

   int tests = 0;
   int fails = 0;
   int clr_cnt = 0;
   int shift_cnt = 0;
   int done_cnt = 0;
   bit mon_en = 1'b0;

   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   dabble_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .bin         (bin),
      .busy        (busy),
      .chain_clr   (chain_clr),
      .chain_shift (chain_shift),
      .chain_din   (chain_din),
      .chain_bcd   (chain_bcd),
      .bcd         (bcd),
      .done        (done)
   );

   // Behavioural double-dabble chain.
   logic [11:0] chain_m = '0;
   assign chain_bcd = chain_m;

   function automatic logic [11:0] dabble_step(input logic [11:0] c, input logic d);
      logic [11:0] t;
      t = c;
      for (int i = 0; i < 3; i++)
         if (t[4*i +: 4] > 4'd4) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      return {t[10:0], d};
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   always @(posedge clk) begin
      if (chain_clr) chain_m <= '0;
      else if (chain_shift) chain_m <= dabble_step(chain_m, chain_din);
   end

   // Per-cycle protocol monitor and activity counters.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         tests++;
         if ((chain_clr & chain_shift) !== 1'b0) begin
            fails++;
            $display("FAIL clr_shift_excl: clr=%b shift=%b, required not both high", chain_clr, chain_shift);
         end
         tests++;
         if ((done & busy) !== 1'b0) begin
            fails++;
            $display("FAIL done_busy_excl: done=%b busy=%b, required not both high", done, busy);
         end
         if (chain_clr) clr_cnt++;
         if (chain_shift) shift_cnt++;
         if (done) done_cnt++;
      end
   end

   task automatic do_start(input logic [WIDTH-1:0] v);
      @(negedge clk);
      bin   = v;
      start = 1'b1;
      exp_q.push_back(to_bcd(int'(v)));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int edges, output bit ok);
      edges = 0;
      ok    = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         edges++;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      tests++;
      if ({busy, chain_clr, chain_shift, chain_din, bcd, done} !== 17'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, required 0",
                  {busy, chain_clr, chain_shift, chain_din, bcd, done});
      end
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy, chain_clr, chain_shift, done} !== 4'd0) begin
         fails++;
         $display("FAIL idle_after_reset: got %b, required 0000", {busy, chain_clr, chain_shift, done});
      end
   endtask

   task automatic test_single_255();
      int edges;
      bit ok;
      logic [11:0] e;
      clr_cnt = 0; shift_cnt = 0; done_cnt = 0;
      do_start(8'd255);
      tests++;
      if ({busy, chain_clr} !== 2'b11) begin
         fails++;
         $display("FAIL e0_busy_clr: got %b, required 11", {busy, chain_clr});
      end
      wait_done(edges, ok);
      tests++;
      if (!ok || edges != 10) begin
         fails++;
         $display("FAIL latency_255: got ok=%0d edges=%0d, required 10", ok, edges);
      end
      e = exp_q.pop_front();
      tests++;
      if (bcd !== e) begin
         fails++;
         $display("FAIL bcd_255: got %h, required %h", bcd, e);
      end
      @(negedge clk);
      #1;
      tests++;
      if (clr_cnt != 1 || shift_cnt != 8 || done_cnt != 1) begin
         fails++;
         $display("FAIL counts_255: clr=%0d shift=%0d done=%0d, required 1 8 1", clr_cnt, shift_cnt, done_cnt);
      end
      @(posedge clk);
      #1;
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL done_width: got %b, required 0", done);
      end
   endtask

   task automatic test_zero_99();
      int edges;
      bit ok;
      logic [11:0] e;
      logic [7:0] vals [2];
      vals[0] = 8'd0;
      vals[1] = 8'd99;
      for (int k = 0; k < 2; k++) begin
         do_start(vals[k]);
         wait_done(edges, ok);
         e = exp_q.pop_front();
         tests++;
         if (!ok || bcd !== e) begin
            fails++;
            $display("FAIL bcd_%0d: got %h ok=%0d, required %h", vals[k], bcd, ok, e);
         end
         tests++;
         if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_in_done_%0d: got %b, required 0", vals[k], busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int edges1, edges2;
      bit ok1, ok2;
      logic [11:0] e;
      @(negedge clk);
      bin   = 8'd128;
      start = 1'b1;
      exp_q.push_back(to_bcd(128));
      exp_q.push_back(to_bcd(7));
      @(posedge clk);
      #1;
      bin = 8'd7;
      wait_done(edges1, ok1);
      e = exp_q.pop_front();
      tests++;
      if (!ok1 || edges1 != 10 || bcd !== e) begin
         fails++;
         $display("FAIL b2b_first: got ok=%0d edges=%0d bcd=%h, required 10 %h", ok1, edges1, bcd, e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || chain_clr !== 1'b1) begin
         fails++;
         $display("FAIL b2b_no_gap: busy=%b clr=%b, required 1 1", busy, chain_clr);
      end
      wait_done(edges2, ok2);
      tests++;
      if (!ok2 || edges2 + 1 != 11) begin
         fails++;
         $display("FAIL b2b_spacing: got ok=%0d spacing=%0d, required 11", ok2, edges2 + 1);
      end
      e = exp_q.pop_front();
      tests++;
      if (bcd !== e) begin
         fails++;
         $display("FAIL b2b_second: got %h, required %h", bcd, e);
      end
   endtask

   task automatic test_ignored_start();
      int done_e;
      logic [11:0] e;
      done_e = 0;
      do_start(8'd200);
      done_cnt = 0;
      bin = 8'd1;
      for (int ed = 1; ed <= 30; ed++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 && done_e == 0) done_e = ed;
         start = (ed == 2 || ed == 5);
      end
      start = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (done_e != 10) begin
         fails++;
         $display("FAIL ignored_latency: got done at edge %0d, required 10", done_e);
      end
      tests++;
      if (done_cnt != 1) begin
         fails++;
         $display("FAIL ignored_single_done: got %0d pulses, required 1", done_cnt);
      end
      e = exp_q.pop_front();
      tests++;
      if (bcd !== e) begin
         fails++;
         $display("FAIL ignored_bcd: got %h, required %h", bcd, e);
      end
   endtask

   task automatic test_reset_abort();
      int edges;
      bit ok;
      logic [11:0] e;
      do_start(8'd173);
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      tests++;
      if ({busy, chain_clr, chain_shift, chain_din, bcd, done} !== 17'd0) begin
         fails++;
         $display("FAIL abort_outputs: got %h, required 0",
                  {busy, chain_clr, chain_shift, chain_din, bcd, done});
      end
      done_cnt = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      #1;
      tests++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_no_done: done pulses=%0d busy=%b, required 0 0", done_cnt, busy);
      end
      do_start(8'd42);
      wait_done(edges, ok);
      e = exp_q.pop_front();
      tests++;
      if (!ok || edges != 10 || bcd !== e) begin
         fails++;
         $display("FAIL abort_restart: got ok=%0d edges=%0d bcd=%h, required 10 %h", ok, edges, bcd, e);
      end
   endtask

   task automatic test_sweep();
      int edges;
      bit ok;
      logic [11:0] e;
      for (int v = 0; v < 256; v++) begin
         do_start(8'(v));
         wait_done(edges, ok);
         e = exp_q.pop_front();
         tests++;
         if (!ok || bcd !== e) begin
            fails++;
            $display("FAIL sweep_%0d: got %h ok=%0d, required %h", v, bcd, ok, e);
         end
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_255();
      test_zero_99();
      test_back_to_back();
      test_ignored_start();
      test_reset_abort();
      test_sweep();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
